// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
//   Boot/load sequencer for the instruction memory and fetch stage. While the CPU
//   is held in reset, a host streams a program into the single-port imem starting
//   at BOOT_ADDR. The controller then spends one cycle reading the boot word and
//   finally releases fetch, which takes imem address control back.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ld_start, ld_len  begin a load of ld_len words (accepted in HOLD, halt low)
//   ld_valid, ld_data loader word stream
//   ld_ready          loader word accepted this cycle
//   ld_done           one-cycle pulse after the last word is written
//   halt              level: abort load / stop CPU, return to HOLD
//   fetch_addr        imem address from fetch
//   mem_addr, mem_we, mem_wdata  imem port
//   cpu_rst           active-high synchronous reset to fetch
//   running           high in RUN only
module imem_boot_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_start,
    input  logic [ADDR_WIDTH:0]   ld_len,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  ld_done,
    input  logic                  halt,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  running
);

    // Largest legal load: the whole memory.
    localparam logic [ADDR_WIDTH:0]   MaxLen  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] BootPtr = BOOT_ADDR[ADDR_WIDTH-1:0];

    typedef enum logic [1:0] {
        StHold,
        StLoad,
        StRelease,
        StRun
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  cpu_rst_q;
    logic                  ld_done_q;
    logic                  running_q;

    logic [ADDR_WIDTH:0]   len_sat;
    logic                  in_load;

    assign len_sat = (ld_len > MaxLen) ? MaxLen : ld_len;
    assign in_load = (state_q == StLoad);

    // Memory port and handshake are decoded from the current state so a word is
    // written in the same cycle it is offered; halt blocks the write immediately.
    always_comb begin
        ld_ready  = in_load & ~halt;
        mem_we    = in_load & ~halt & ld_valid;
        mem_addr  = in_load ? wr_ptr_q : fetch_addr;
        mem_wdata = ld_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHold;
            wr_ptr_q    <= BootPtr;
            remaining_q <= '0;
            cpu_rst_q   <= 1'b1;
            ld_done_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            if (halt) begin
                state_q   <= StHold;
                cpu_rst_q <= 1'b1;
                running_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StHold: begin
                        if (ld_start) begin
                            remaining_q <= len_sat;
                            wr_ptr_q    <= BootPtr;
                            state_q     <= (len_sat != '0) ? StLoad : StRelease;
                        end
                    end
                    StLoad: begin
                        if (ld_valid) begin
                            // Pointer wraps naturally past the top of memory.
                            wr_ptr_q    <= wr_ptr_q + 1'b1;
                            remaining_q <= remaining_q - 1'b1;
                            if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
                                ld_done_q <= 1'b1;
                                state_q   <= StRelease;
                            end
                        end
                    end
                    StRelease: begin
                        // Fetch still in reset presents BOOT_ADDR this cycle.
                        state_q   <= StRun;
                        cpu_rst_q <= 1'b0;
                        running_q <= 1'b1;
                    end
                    StRun: begin
                        state_q <= StRun;
                    end
                    default: begin
                        state_q <= StHold;
                    end
                endcase
            end
        end
    end

    assign ld_done = ld_done_q;
    assign cpu_rst = cpu_rst_q;
    assign running = running_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl
//   Two controller instances (boot word 0 and boot word 510) share the loader and
//   control stimulus. A reference model tracks the load as a phase plus word
//   counts and computes write addresses arithmetically; a bench-side imem captures
//   the real writes and is compared with the model image at the end.
module tb_imem_boot_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 512;

    logic          clk;
    logic          rst_n;
    logic          ld_start;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          halt;
    logic [AW-1:0] fa    [2];
    logic          rdy   [2];
    logic          done  [2];
    logic [AW-1:0] maddr [2];
    logic          we    [2];
    logic [DW-1:0] wd    [2];
    logic          crst  [2];
    logic          run   [2];

    int errors = 0;
    int checks = 0;

    imem_boot_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BOOT_ADDR(32'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(rdy[0]), .ld_done(done[0]),
        .halt(halt), .fetch_addr(fa[0]), .mem_addr(maddr[0]), .mem_we(we[0]),
        .mem_wdata(wd[0]), .cpu_rst(crst[0]), .running(run[0])
    );

    imem_boot_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BOOT_ADDR(32'd510)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(rdy[1]), .ld_done(done[1]),
        .halt(halt), .fetch_addr(fa[1]), .mem_addr(maddr[1]), .mem_we(we[1]),
        .mem_wdata(wd[1]), .cpu_rst(crst[1]), .running(run[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side imem, written only by what the DUTs actually drive.
    logic [DW-1:0] imem [2][DEPTH];
    always @(posedge clk) begin
        if (we[0]) imem[0][maddr[0]] <= wd[0];
        if (we[1]) imem[1][maddr[1]] <= wd[1];
    end

    // Reference model
    typedef enum int {MHold, MLoad, MRelease, MRun} mphase_e;
    mphase_e       m_phase;
    int            m_left;
    int            m_wcount;
    bit            m_done;
    logic [DW-1:0] mmem [2][DEPTH];

    function automatic int boot_of(input int k);
        return (k == 0) ? 0 : 510;
    endfunction

    function automatic int exp_addr(input int k);
        return (boot_of(k) + m_wcount) % DEPTH;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = MHold;
        m_left   = 0;
        m_wcount = 0;
        m_done   = 0;
    endtask

    task automatic model_next();
        m_done = 0;
        if (halt) begin
            m_phase = MHold;
        end else begin
            case (m_phase)
                MHold: if (ld_start) begin
                    m_left   = (int'(ld_len) > DEPTH) ? DEPTH : int'(ld_len);
                    m_wcount = 0;
                    m_phase  = (m_left > 0) ? MLoad : MRelease;
                end
                MLoad: if (ld_valid) begin
                    for (int k = 0; k < 2; k++) mmem[k][exp_addr(k)] = ld_data;
                    m_wcount++;
                    m_left--;
                    if (m_left == 0) begin
                        m_done  = 1;
                        m_phase = MRelease;
                    end
                end
                MRelease: m_phase = MRun;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            bit e_rdy;
            bit e_we;
            e_rdy = (m_phase == MLoad) && !halt;
            e_we  = e_rdy && ld_valid;
            check_eq($sformatf("ld_ready[%0d]", k), 64'(rdy[k]), 64'(e_rdy));
            check_eq($sformatf("mem_we[%0d]", k), 64'(we[k]), 64'(e_we));
            if (e_we) begin
                check_eq($sformatf("wr_addr[%0d]", k), 64'(maddr[k]), 64'(exp_addr(k)));
                check_eq($sformatf("wr_data[%0d]", k), 64'(wd[k]), 64'(ld_data));
            end else if (m_phase != MLoad) begin
                check_eq($sformatf("fetch_addr_pass[%0d]", k), 64'(maddr[k]), 64'(fa[k]));
            end
            if (m_phase == MRelease && rst_n)
                check_eq($sformatf("boot_read[%0d]", k), 64'(imem[k][maddr[k]]),
                         64'(mmem[k][boot_of(k)]));
            check_eq($sformatf("ld_done[%0d]", k), 64'(done[k]), 64'(m_done));
            check_eq($sformatf("cpu_rst[%0d]", k), 64'(crst[k]), 64'(m_phase != MRun));
            check_eq($sformatf("running[%0d]", k), 64'(run[k]), 64'(m_phase == MRun));
        end
    endtask

    // One clock: drive at negedge, check 1 time unit later, advance model at posedge.
    task automatic step(input bit start, input int len, input bit valid,
                        input logic [DW-1:0] data, input bit hlt);
        @(negedge clk);
        ld_start = start;
        ld_len   = len[AW:0];
        ld_valid = valid;
        ld_data  = data;
        halt     = hlt;
        // Fetch held in reset presents its boot address.
        for (int k = 0; k < 2; k++)
            fa[k] = (m_phase == MRun) ? AW'($urandom_range(0, DEPTH - 1)) : AW'(boot_of(k));
        #1;
        check_outputs();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_next();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, $urandom, 0);
    endtask

    initial begin
        logic [DW-1:0] words [4];
        bit            gaps  [6];
        words = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
        gaps  = '{1, 0, 0, 1, 0, 1};

        rst_n = 1'b0; ld_start = 0; ld_len = '0; ld_valid = 0; ld_data = '0; halt = 0;
        fa[0] = '0; fa[1] = '0;
        model_reset();
        idle(2);
        #2 rst_n = 1'b1;
        idle(1);

        // Back-to-back load of four words, then release and run.
        step(1, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, words[i], 0);
        idle(3);
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("boot_word_A[%0d]", k), 64'(imem[k][boot_of(k)]), 64'(words[0]));
        check_eq("wrap_word_C", 64'(imem[1][0]), 64'(words[2]));
        step(0, 0, 0, 0, 1);
        idle(1);

        // Load of three words with valid gaps; extra valid after completion.
        step(1, 3, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, gaps[i], $urandom, 0);
        step(0, 0, 1, $urandom, 0);
        step(0, 0, 1, $urandom, 0);
        step(0, 0, 0, 0, 1);

        // Halt after two of five words; aborted word must not be written.
        step(1, 5, 0, 0, 0);
        step(0, 0, 1, $urandom, 0);
        step(0, 0, 1, $urandom, 0);
        step(0, 0, 1, 32'hDEAD_BEEF, 1);
        step(1, 2, 0, 0, 1);
        idle(2);

        // Zero-length load, then ld_start in RUN is ignored.
        step(1, 0, 0, 0, 0);
        idle(2);
        step(1, 4, 1, $urandom, 0);
        idle(1);
        step(0, 0, 0, 0, 1);

        // Async reset in the middle of a load.
        step(1, 6, 0, 0, 0);
        step(0, 0, 1, $urandom, 0);
        step(0, 0, 1, $urandom, 0);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_mem_we[%0d]", k), 64'(we[k]), 64'd0);
            check_eq($sformatf("rst_cpu_rst[%0d]", k), 64'(crst[k]), 64'd1);
            check_eq($sformatf("rst_ld_ready[%0d]", k), 64'(rdy[k]), 64'd0);
        end
        model_reset();
        step(1, 3, 1, $urandom, 0);
        #2 rst_n = 1'b1;
        idle(1);

        // Randomized traffic, including oversized lengths and stray halts.
        for (int i = 0; i < 1500; i++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 8);
            step($urandom_range(0, 7) == 0, len, $urandom_range(0, 2) != 0, $urandom,
                 $urandom_range(0, 59) == 0);
        end
        idle(2);

        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++)
                check_eq($sformatf("image[%0d][%0d]", k, a), 64'(imem[k][a]), 64'(mmem[k][a]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
